// File: rtl/rd_return_assembler_if.sv
// rd_return_assembler_if: bundles the READ command, DQ capture and response signals of
// rd_return_assembler.
//   slave  : the assembler side (takes commands and DQ beats, drives responses and status)
//   master : the controller/PHY/host side
// Parity ports exist only when RD_RET_PARITY_EN is defined.
interface rd_return_assembler_if #(
  parameter int unsigned BEATS = 4,
  parameter int unsigned DQ_W  = 8
);
  logic                     rd_issue;
  logic                     BA;
  logic [15:0]              row;
  logic [9:0]               col;
  logic [DQ_W-1:0]          dq_i;
  logic [BEATS*DQ_W-1:0]    rdata_o;
  logic [31:0]              raddr_o;
  logic                     rvalid_o;
  logic                     rready_i;
  logic                     overflow_o;
  logic                     err_o;
  logic                     busy_o;
`ifdef RD_RET_PARITY_EN
  logic                     dq_par_i;
  logic                     par_err_o;
`endif

  modport master (
    output rd_issue, BA, row, col, dq_i, rready_i,
`ifdef RD_RET_PARITY_EN
    output dq_par_i,
    input  par_err_o,
`endif
    input  rdata_o, raddr_o, rvalid_o, overflow_o, err_o, busy_o
  );

  modport slave (
    input  rd_issue, BA, row, col, dq_i, rready_i,
`ifdef RD_RET_PARITY_EN
    input  dq_par_i,
    output par_err_o,
`endif
    output rdata_o, raddr_o, rvalid_o, overflow_o, err_o, busy_o
  );
endinterface

// File: rtl/rd_return_assembler.sv
// rd_return_assembler: read-return side of the DDR5 controller datapath.
// Each accepted READ is tracked with its reconstructed flat address; CL cycles after the
// issue strobe BEATS data beats are shifted in from DQ and the {address, data} pair is
// pushed into a DEPTH-entry valid/ready output FIFO.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   bus (slave)    : rd_issue/BA/row/col command capture, dq_i beats, rready_i,
//                    rdata_o/raddr_o/rvalid_o head entry, overflow_o/err_o sticky flags,
//                    busy_o activity indicator
// Optional feature macro: RD_RET_PARITY_EN adds dq_par_i (even parity per beat) and
// par_err_o (per-response parity error flag).
// Assumes CL >= 2, BEATS >= 2 and DEPTH a power of two >= 2.
module rd_return_assembler #(
  parameter int unsigned CL    = 22,
  parameter int unsigned BEATS = 4,
  parameter int unsigned DQ_W  = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  rd_return_assembler_if.slave bus
);

  localparam int unsigned W    = BEATS * DQ_W;
  // Enough entries for every read that can legally be outstanding at minimum spacing.
  localparam int unsigned NTRK = (CL + BEATS + BEATS - 1) / BEATS;
  localparam int unsigned TW   = (NTRK > 1) ? $clog2(NTRK) : 1;
  localparam int unsigned TNW  = $clog2(NTRK + 1);
  localparam int unsigned CW   = $clog2(CL);
  localparam int unsigned BW   = $clog2(BEATS);
  localparam int unsigned SW   = $clog2(BEATS + 1);
  localparam int unsigned AW   = $clog2(DEPTH);

  // In-flight tracker (circular buffer, oldest at trk_rd_q).
  logic [31:0]    trk_addr_q [NTRK];
  logic [31:0]    trk_addr_d [NTRK];
  logic [CW-1:0]  trk_cnt_q  [NTRK];
  logic [CW-1:0]  trk_cnt_d  [NTRK];
  logic [TW-1:0]  trk_wr_q, trk_wr_d, trk_rd_q, trk_rd_d;
  logic [TNW-1:0] trk_num_q, trk_num_d;

  // Cycles since the last accepted issue, saturating at BEATS.
  logic [SW-1:0]  since_q, since_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [W-1:0]   asm_q, asm_d;
  logic           err_q, err_d;
  logic           ovf_q, ovf_d;

  // Output FIFO.
  logic [31:0]    fifo_addr_q [DEPTH];
  logic [31:0]    fifo_addr_d [DEPTH];
  logic [W-1:0]   fifo_data_q [DEPTH];
  logic [W-1:0]   fifo_data_d [DEPTH];
  logic [AW-1:0]  fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [AW:0]    fifo_num_q, fifo_num_d;

  logic           capture, last_beat, accept, pop, full, push_ok;
  logic [31:0]    new_addr;
  logic           rvalid;
  logic           unused_addr_bits;

`ifdef RD_RET_PARITY_EN
  logic           fifo_par_q [DEPTH];
  logic           fifo_par_d [DEPTH];
  logic           par_acc_q, par_acc_d;
  logic           beat_bad;
`endif

  function automatic logic [TW-1:0] trk_inc(logic [TW-1:0] p);
    return (p == TW'(NTRK - 1)) ? '0 : p + TW'(1);
  endfunction

  // Inverse address map: only BA, row[7:0] and col[7:0] reach the flat address.
  assign new_addr         = {11'b0, bus.BA, 4'b0, bus.row[7:0], bus.col[7:0]};
  assign unused_addr_bits = ^{bus.row[15:8], bus.col[9:8]};

  always_comb begin
    trk_addr_d  = trk_addr_q;
    trk_cnt_d   = trk_cnt_q;
    trk_wr_d    = trk_wr_q;
    trk_rd_d    = trk_rd_q;
    trk_num_d   = trk_num_q;
    since_d     = since_q;
    beat_d      = beat_q;
    asm_d       = asm_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    fifo_wr_d   = fifo_wr_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_num_d  = fifo_num_q;
`ifdef RD_RET_PARITY_EN
    fifo_par_d  = fifo_par_q;
    par_acc_d   = par_acc_q;
    beat_bad    = (^bus.dq_i) != bus.dq_par_i;
`endif

    // All countdowns run every cycle; the head's reaching zero starts its capture.
    for (int i = 0; i < int'(NTRK); i++) begin
      if (trk_cnt_q[i] != '0) trk_cnt_d[i] = trk_cnt_q[i] - CW'(1);
    end
    if (since_q != SW'(BEATS)) since_d = since_q + SW'(1);

    capture   = (trk_num_q != '0) && (trk_cnt_q[trk_rd_q] == '0);
    last_beat = capture && (beat_q == BW'(BEATS - 1));
    accept    = bus.rd_issue && (since_q == SW'(BEATS)) && (trk_num_q != TNW'(NTRK));

    if (bus.rd_issue && (since_q != SW'(BEATS))) err_d = 1'b1;

    // Beats enter at the top so that beat 0 ends up in the LSBs.
    if (capture) begin
      asm_d  = {bus.dq_i, asm_q[W-1:DQ_W]};
      beat_d = last_beat ? '0 : beat_q + BW'(1);
`ifdef RD_RET_PARITY_EN
      par_acc_d = last_beat ? 1'b0 : (par_acc_q | beat_bad);
`endif
    end

    // Countdown stores cycles remaining before beat 0, hence CL-1.
    if (accept) begin
      trk_addr_d[trk_wr_q] = new_addr;
      trk_cnt_d[trk_wr_q]  = CW'(CL - 1);
      trk_wr_d             = trk_inc(trk_wr_q);
      since_d              = SW'(1);
    end
    if (last_beat) trk_rd_d = trk_inc(trk_rd_q);
    unique case ({accept, last_beat})
      2'b10:   trk_num_d = trk_num_q + TNW'(1);
      2'b01:   trk_num_d = trk_num_q - TNW'(1);
      default: trk_num_d = trk_num_q;
    endcase

    // Pop is evaluated before push so a full FIFO being drained still takes the burst.
    pop     = (fifo_num_q != '0) && bus.rready_i;
    full    = (fifo_num_q == (AW + 1)'(DEPTH));
    push_ok = last_beat && (!full || pop);
    if (last_beat && full && !pop) ovf_d = 1'b1;

    if (pop) fifo_rd_d = fifo_rd_q + AW'(1);
    if (push_ok) begin
      fifo_addr_d[fifo_wr_q] = trk_addr_q[trk_rd_q];
      fifo_data_d[fifo_wr_q] = {bus.dq_i, asm_q[W-1:DQ_W]};
`ifdef RD_RET_PARITY_EN
      fifo_par_d[fifo_wr_q]  = par_acc_q | beat_bad;
`endif
      fifo_wr_d              = fifo_wr_q + AW'(1);
    end
    unique case ({push_ok, pop})
      2'b10:   fifo_num_d = fifo_num_q + (AW + 1)'(1);
      2'b01:   fifo_num_d = fifo_num_q - (AW + 1)'(1);
      default: fifo_num_d = fifo_num_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trk_wr_q   <= '0;
      trk_rd_q   <= '0;
      trk_num_q  <= '0;
      since_q    <= SW'(BEATS);
      beat_q     <= '0;
      asm_q      <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_num_q <= '0;
`ifdef RD_RET_PARITY_EN
      par_acc_q  <= 1'b0;
`endif
    end else begin
      trk_wr_q   <= trk_wr_d;
      trk_rd_q   <= trk_rd_d;
      trk_num_q  <= trk_num_d;
      since_q    <= since_d;
      beat_q     <= beat_d;
      asm_q      <= asm_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_num_q <= fifo_num_d;
`ifdef RD_RET_PARITY_EN
      par_acc_q  <= par_acc_d;
`endif
    end
  end

  // Storage only; validity comes from the reset pointers and counts above.
  always_ff @(posedge clk) begin
    trk_addr_q  <= trk_addr_d;
    trk_cnt_q   <= trk_cnt_d;
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
`ifdef RD_RET_PARITY_EN
    fifo_par_q  <= fifo_par_d;
`endif
  end

  // Outputs are forced low while rst is asserted so they read 0 from the first reset cycle.
  assign rvalid         = !rst && (fifo_num_q != '0);
  assign bus.rvalid_o   = rvalid;
  assign bus.raddr_o    = rvalid ? fifo_addr_q[fifo_rd_q] : '0;
  assign bus.rdata_o    = rvalid ? fifo_data_q[fifo_rd_q] : '0;
  assign bus.overflow_o = !rst && ovf_q;
  assign bus.err_o      = !rst && err_q;
  assign bus.busy_o     = !rst && ((trk_num_q != '0) || (fifo_num_q != '0));
`ifdef RD_RET_PARITY_EN
  assign bus.par_err_o  = rvalid && fifo_par_q[fifo_rd_q];
`endif

endmodule

// File: tb/tb_rd_return_assembler.sv
module tb_rd_return_assembler;
  localparam int unsigned CL    = 22;
  localparam int unsigned BEATS = 4;
  localparam int unsigned DQ_W  = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = BEATS * DQ_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rd_return_assembler_if #(.BEATS(BEATS), .DQ_W(DQ_W)) bus ();

  rd_return_assembler #(.CL(CL), .BEATS(BEATS), .DQ_W(DQ_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_dq(logic [DQ_W-1:0] v);
    bus.dq_i = v;
`ifdef RD_RET_PARITY_EN
    bus.dq_par_i = ^v;
`endif
  endtask

  task automatic drive_idle();
    bus.rd_issue = 1'b0;
    bus.BA       = 1'b0;
    bus.row      = '0;
    bus.col      = '0;
    bus.rready_i = 1'b0;
    set_dq('0);
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Expectation helpers: the spec's address rule and the bench's DQ pattern.
  function automatic logic [31:0] map_addr(logic ba, logic [15:0] row, logic [9:0] col);
    return {11'b0, ba, 4'b0, row[7:0], col[7:0]};
  endfunction
  function automatic logic [15:0] row_of(int i);
    return 16'(32'h5A00 + i * 32'h0111);
  endfunction
  function automatic logic [9:0] col_of(int i);
    return 10'(32'h2C0 + i * 3);
  endfunction
  function automatic logic [31:0] addr_of(int i);
    logic [31:0] b = i;
    return map_addr(b[0], row_of(i), col_of(i));
  endfunction
  function automatic logic [DQ_W-1:0] pat(int c);
    return DQ_W'(c * 7 + 3);
  endfunction
  // Burst for a read issued at relative cycle t: beat k was driven at t+CL+k.
  function automatic logic [W-1:0] burst_of(int t);
    logic [W-1:0] d;
    for (int k = 0; k < int'(BEATS); k++) d[k*DQ_W +: DQ_W] = pat(t + int'(CL) + k);
    return d;
  endfunction

  task automatic drive_read(logic en, int i);
    logic [31:0] b = i;
    bus.rd_issue = en;
    bus.BA       = b[0];
    bus.row      = row_of(i);
    bus.col      = col_of(i);
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    n_total++;
    if ({bus.rvalid_o, bus.err_o, bus.overflow_o, bus.busy_o, bus.raddr_o, bus.rdata_o} !== '0)
      $display("FAIL reset_during: got v=%0b e=%0b o=%0b b=%0b a=%h d=%h want all 0",
               bus.rvalid_o, bus.err_o, bus.overflow_o, bus.busy_o, bus.raddr_o, bus.rdata_o);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick(3);
    n_total++;
    if ({bus.rvalid_o, bus.err_o, bus.overflow_o, bus.busy_o, bus.raddr_o, bus.rdata_o} !== '0)
      $display("FAIL reset_after: got v=%0b e=%0b o=%0b b=%0b a=%h d=%h want all 0",
               bus.rvalid_o, bus.err_o, bus.overflow_o, bus.busy_o, bus.raddr_o, bus.rdata_o);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    bus.rd_issue = 1'b1;
    bus.BA       = 1'b1;
    bus.row      = 16'h00A5;
    bus.col      = 10'h03C;
    tick();
    drive_idle();
    n_total++;
    if (bus.busy_o !== 1'b1) $display("FAIL single_busy_rise: got %0b want 1", bus.busy_o);
    else n_pass++;
    tick(CL - 1);
    set_dq(8'h11); tick();
    set_dq(8'h22); tick();
    set_dq(8'h33); tick();
    set_dq(8'h44);
    n_total++;
    if (bus.rvalid_o !== 1'b0) $display("FAIL single_early_valid: got %0b want 0", bus.rvalid_o);
    else n_pass++;
    tick();
    set_dq(8'h00);
    for (int h = 0; h < 3; h++) begin
      n_total++;
      if ({bus.rvalid_o, bus.raddr_o, bus.rdata_o} !== {1'b1, 32'h0010_A53C, 32'h4433_2211})
        $display("FAIL single_resp[%0d]: got v=%0b a=%h d=%h want v=1 a=0010a53c d=44332211",
                 h, bus.rvalid_o, bus.raddr_o, bus.rdata_o);
      else n_pass++;
      tick();
    end
    bus.rready_i = 1'b1;
    tick();
    bus.rready_i = 1'b0;
    n_total++;
    if ({bus.rvalid_o, bus.busy_o, bus.err_o} !== 3'b000)
      $display("FAIL single_drain: got v=%0b b=%0b e=%0b want 0 0 0",
               bus.rvalid_o, bus.busy_o, bus.err_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int r = 0; r < 40; r++) begin
      int c;
      int i;
      logic ev;
      drive_read((r % 4 == 0) && (r < 12), r / 4);
      set_dq(pat(r));
      bus.rready_i = 1'b1;
      tick();
      c  = r + 1;
      ev = (c == 26) || (c == 30) || (c == 34);
      i  = (c - 26) / 4;
      n_total++;
      if (bus.rvalid_o !== ev || (ev && {bus.raddr_o, bus.rdata_o} !== {addr_of(i), burst_of(4*i)}))
        $display("FAIL back_to_back c=%0d: got v=%0b a=%h d=%h want v=%0b a=%h d=%h", c,
                 bus.rvalid_o, bus.raddr_o, bus.rdata_o, ev, addr_of(i), burst_of(4*i));
      else n_pass++;
    end
    drive_idle();
    n_total++;
    if (bus.err_o !== 1'b0) $display("FAIL back_to_back_err: got %0b want 0", bus.err_o);
    else n_pass++;
  endtask

  task automatic test_spacing();
    int nv = 0;
    logic [31:0] seen = '0;
    do_reset();
    for (int r = 0; r < 36; r++) begin
      drive_read((r == 0) || (r == 2), r == 0 ? 0 : 1);
      set_dq(pat(r));
      bus.rready_i = 1'b1;
      tick();
      if (r + 1 == 2 || r + 1 == 3) begin
        n_total++;
        if (bus.err_o !== (r + 1 == 3))
          $display("FAIL spacing_err c=%0d: got %0b want %0b", r + 1, bus.err_o, r + 1 == 3);
        else n_pass++;
      end
      if (bus.rvalid_o === 1'b1) begin
        nv++;
        seen = bus.raddr_o;
      end
    end
    drive_idle();
    n_total++;
    if (nv != 1 || seen !== addr_of(0))
      $display("FAIL spacing_resp: got count=%0d a=%h want count=1 a=%h", nv, seen, addr_of(0));
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int r = 0; r < 56; r++) begin
      int c;
      int i;
      logic ev;
      drive_read((r % 4 == 0) && (r <= 16), r / 4);
      set_dq(pat(r));
      bus.rready_i = (r >= 44);
      tick();
      c  = r + 1;
      ev = (c >= 26) && (c <= 47);
      i  = (c <= 44) ? 0 : c - 44;
      n_total++;
      if (bus.rvalid_o !== ev || (ev && {bus.raddr_o, bus.rdata_o} !== {addr_of(i), burst_of(4*i)}))
        $display("FAIL backpressure c=%0d: got v=%0b a=%h d=%h want v=%0b a=%h d=%h", c,
                 bus.rvalid_o, bus.raddr_o, bus.rdata_o, ev, addr_of(i), burst_of(4*i));
      else n_pass++;
      if (c == 41 || c == 42) begin
        n_total++;
        if (bus.overflow_o !== (c == 42))
          $display("FAIL overflow c=%0d: got %0b want %0b", c, bus.overflow_o, c == 42);
        else n_pass++;
      end
    end
    drive_idle();
  endtask

  // Runs straight after the backpressure test so overflow_o is still set on entry.
  task automatic test_reset_mid_burst();
    int bad = 0;
    for (int r = 0; r < 25; r++) begin
      drive_read((r == 0) || (r == 1), 5);
      set_dq(pat(r));
      rst = (r == int'(CL) + 2);
      tick();
      if (r == 1) begin
        n_total++;
        if ({bus.busy_o, bus.err_o, bus.overflow_o} !== 3'b111)
          $display("FAIL mid_pre: got b=%0b e=%0b o=%0b want 1 1 1",
                   bus.busy_o, bus.err_o, bus.overflow_o);
        else n_pass++;
      end
    end
    rst = 1'b0;
    drive_idle();
    for (int r = 0; r < 20; r++) begin
      set_dq(pat(r));
      bus.rready_i = r[0];
      if ({bus.rvalid_o, bus.busy_o, bus.err_o, bus.overflow_o} !== 4'b0000) bad++;
      tick();
    end
    n_total++;
    if (bad != 0) $display("FAIL mid_post: got %0d nonzero cycles want 0", bad);
    else n_pass++;
    drive_idle();
  endtask

  // Randomised traffic against a transaction-level model: reads that respect the spacing
  // become responses CL+BEATS cycles later, queued in a DEPTH-bounded FIFO.
  task automatic test_random();
    int          pend_t[$];
    logic [31:0] pend_a[$];
    logic [31:0] exp_a[$];
    logic [W-1:0] exp_d[$];
    logic [DQ_W-1:0] hist [int];
    int   last_acc = -100;
    logic m_err = 1'b0;
    logic m_ovf = 1'b0;
    int   bad_data = 0;
    int   bad_flag = 0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic iss;
      logic rr;
      logic pop;
      int   sz;
      logic [31:0] a;
      logic [W-1:0] d;
      iss = ($urandom_range(0, 3) == 0);
      rr  = ((c % 300) < 180) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      bus.rd_issue = iss;
      bus.BA       = 1'($urandom);
      bus.row      = 16'($urandom);
      bus.col      = 10'($urandom);
      bus.rready_i = rr;
      hist[c]      = DQ_W'($urandom);
      set_dq(hist[c]);
      a = map_addr(bus.BA, bus.row, bus.col);
      sz  = exp_a.size();
      pop = (sz > 0) && rr;
      if (pop) begin
        void'(exp_a.pop_front());
        void'(exp_d.pop_front());
      end
      if (pend_t.size() > 0 && c == pend_t[0] + int'(CL + BEATS) - 1) begin
        for (int k = 0; k < int'(BEATS); k++) d[k*DQ_W +: DQ_W] = hist[pend_t[0] + int'(CL) + k];
        if (sz < int'(DEPTH) || pop) begin
          exp_a.push_back(pend_a[0]);
          exp_d.push_back(d);
        end else m_ovf = 1'b1;
        void'(pend_t.pop_front());
        void'(pend_a.pop_front());
      end
      if (iss) begin
        if (c - last_acc >= int'(BEATS)) begin
          pend_t.push_back(c);
          pend_a.push_back(a);
          last_acc = c;
        end else m_err = 1'b1;
      end
      tick();
      n_total++;
      if (bus.rvalid_o !== (exp_a.size() > 0) ||
          (exp_a.size() > 0 && {bus.raddr_o, bus.rdata_o} !== {exp_a[0], exp_d[0]})) begin
        if (bad_data < 5)
          $display("FAIL random_resp c=%0d: got v=%0b a=%h d=%h want v=%0b a=%h d=%h", c,
                   bus.rvalid_o, bus.raddr_o, bus.rdata_o, exp_a.size() > 0,
                   exp_a.size() > 0 ? exp_a[0] : 32'h0, exp_d.size() > 0 ? exp_d[0] : '0);
        bad_data++;
      end else n_pass++;
      n_total++;
      if ({bus.err_o, bus.overflow_o, bus.busy_o} !==
          {m_err, m_ovf, (pend_t.size() > 0) || (exp_a.size() > 0)}) begin
        if (bad_flag < 5)
          $display("FAIL random_flags c=%0d: got e=%0b o=%0b b=%0b want e=%0b o=%0b b=%0b", c,
                   bus.err_o, bus.overflow_o, bus.busy_o, m_err, m_ovf,
                   (pend_t.size() > 0) || (exp_a.size() > 0));
        bad_flag++;
      end else n_pass++;
    end
    drive_idle();
  endtask

`ifdef RD_RET_PARITY_EN
  task automatic test_parity();
    do_reset();
    for (int r = 0; r < 32; r++) begin
      int c;
      drive_read((r == 0) || (r == 4), r / 4);
      set_dq(pat(r));
      if (r == int'(CL) + 2) bus.dq_par_i = ~(^pat(r));
      bus.rready_i = 1'b1;
      tick();
      c = r + 1;
      if (c == 26 || c == 30) begin
        n_total++;
        if ({bus.rvalid_o, bus.par_err_o, bus.rdata_o} !== {1'b1, c == 26, burst_of(c - 26)})
          $display("FAIL parity c=%0d: got v=%0b p=%0b d=%h want v=1 p=%0b d=%h", c,
                   bus.rvalid_o, bus.par_err_o, bus.rdata_o, c == 26, burst_of(c - 26));
        else n_pass++;
      end
    end
    drive_idle();
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single();
    test_back_to_back();
    test_spacing();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
`ifdef RD_RET_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
